nibble_serial_adder_ctrl: RTL and testbench

- Multi-cycle sequencer that adds two WIDTH-bit operands through a single 4-bit adder slice, one nibble per clock, LSB nibble first.
- A carry register links each nibble to the next.
- Sits in the adder datapath wherever wide additions are needed and area matters more than latency.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 20 ++
 rtl/nibble_serial_adder_ctrl_slice.sv | 30 +++
 rtl/nibble_serial_adder_ctrl.sv | 155 +++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Optional subtract support is enabled with the NIBBLE_ADD_SUB_EN macro.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble index width: ceil(log2(WIDTH/4)), never less than one bit
    function automatic int idxWidth(input int width);
        int nibbles;
        nibbles = width / NIBBLE_W;
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Purely combinational 4-bit adder slice used one nibble per clock by the controller.
// With NIBBLE_ADD_SUB_EN the carry into bit 3 is exported for signed overflow detection.
module nibble_add_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
`ifdef NIBBLE_ADD_SUB_EN
    output logic                carry3_o,
`endif
    output logic                cout_o
);

    logic [NIBBLE_W:0] total;

    assign total           = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};
    assign {cout_o, sum_o} = total;

`ifdef NIBBLE_ADD_SUB_EN
    logic [NIBBLE_W-1:0] lowTotal;

    // Carry into the top bit comes from adding only the lower three bits
    assign lowTotal = {1'b0, a_i[NIBBLE_W-2:0]} + {1'b0, b_i[NIBBLE_W-2:0]}
                    + {{(NIBBLE_W-1){1'b0}}, cin_i};
    assign carry3_o = lowTotal[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit slice, LSB nibble first.
// Define NIBBLE_ADD_SUB_EN to add the Sub input and Overflow output.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             CarryIn,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             Sub,
    output logic             Overflow,
`endif
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idxWidth(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             stateQ, stateD;
    logic [IDX_W-1:0]   idxQ, idxD;
    logic [WIDTH-1:0]   aQ, aD;
    logic [WIDTH-1:0]   bQ, bD;
    logic [WIDTH-1:0]   resultQ, resultD;
    logic               carryQ, carryD;
    logic               carryOutQ, carryOutD;
    logic               subQ, subD;

    logic [NIBBLE_W-1:0] sliceA, sliceB, sliceSum;
    logic                sliceCout;
    logic [IDX_W+1:0]    bitBase;

`ifdef NIBBLE_ADD_SUB_EN
    logic overflowQ, overflowD;
    logic sliceCarry3;
`endif

    assign bitBase = {idxQ, 2'b00};
    assign sliceA  = aQ[bitBase +: NIBBLE_W];
    // Subtraction feeds the inverted B nibble; subQ is constant 0 in add-only builds
    assign sliceB  = bQ[bitBase +: NIBBLE_W] ^ {NIBBLE_W{subQ}};

    nibble_add_slice uSlice (
        .a_i      (sliceA),
        .b_i      (sliceB),
        .cin_i    (carryQ),
        .sum_o    (sliceSum),
`ifdef NIBBLE_ADD_SUB_EN
        .carry3_o (sliceCarry3),
`endif
        .cout_o   (sliceCout)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ    <= IDLE;
            idxQ      <= '0;
            aQ        <= '0;
            bQ        <= '0;
            resultQ   <= '0;
            carryQ    <= 1'b0;
            carryOutQ <= 1'b0;
            subQ      <= 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
            overflowQ <= 1'b0;
`endif
        end else begin
            stateQ    <= stateD;
            idxQ      <= idxD;
            aQ        <= aD;
            bQ        <= bD;
            resultQ   <= resultD;
            carryQ    <= carryD;
            carryOutQ <= carryOutD;
            subQ      <= subD;
`ifdef NIBBLE_ADD_SUB_EN
            overflowQ <= overflowD;
`endif
        end
    end

    always_comb begin
        stateD    = stateQ;
        idxD      = idxQ;
        aD        = aQ;
        bD        = bQ;
        resultD   = resultQ;
        carryD    = carryQ;
        carryOutD = carryOutQ;
        subD      = subQ;
`ifdef NIBBLE_ADD_SUB_EN
        overflowD = overflowQ;
`endif

        case (stateQ)
            IDLE: begin
                if (InValid) begin
                    aD      = inA;
                    bD      = inB;
                    resultD = '0;
                    idxD    = '0;
                    stateD  = RUN;
`ifdef NIBBLE_ADD_SUB_EN
                    subD    = Sub;
                    carryD  = Sub ? 1'b1 : CarryIn;
`else
                    subD    = 1'b0;
                    carryD  = CarryIn;
`endif
                end
            end
            RUN: begin
                resultD[bitBase +: NIBBLE_W] = sliceSum;
                carryD                       = sliceCout;
                if (idxQ == LAST_IDX) begin
                    carryOutD = sliceCout;
`ifdef NIBBLE_ADD_SUB_EN
                    overflowD = sliceCarry3 ^ sliceCout;
`endif
                    idxD      = '0;
                    stateD    = DONE;
                end else begin
                    idxD = idxQ + 1'b1;
                end
            end
            DONE: begin
                if (OutReady) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
                idxD   = '0;
            end
        endcase
    end

    assign InReady  = (stateQ == IDLE);
    assign OutValid = (stateQ == DONE);
    assign Result   = resultQ;
    assign CarryOut = carryOutQ;
`ifdef NIBBLE_ADD_SUB_EN
    assign Overflow = overflowQ;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl; covers subtraction when NIBBLE_ADD_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             carryIn;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             carryOut;
`ifdef NIBBLE_ADD_SUB_EN
    logic             sub;
    logic             overflow;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ov;
    } exp_t;

    exp_t expQueue[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .InValid  (inValid),
        .InReady  (inReady),
        .inA      (inA),
        .inB      (inB),
        .CarryIn  (carryIn),
`ifdef NIBBLE_ADD_SUB_EN
        .Sub      (sub),
        .Overflow (overflow),
`endif
        .OutValid (outValid),
        .OutReady (outReady),
        .Result   (result),
        .CarryOut (carryOut)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every result handshake must match the oldest queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b0 && outValid === 1'b1 && outReady === 1'b1) begin
            checkOutput("pending_expect", 32'(expQueue.size() > 0), 32'd1);
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                checkOutput("result", 32'(result), 32'(e.res));
                checkOutput("carry_out", 32'(carryOut), 32'(e.carry));
`ifdef NIBBLE_ADD_SUB_EN
                checkOutput("overflow", 32'(overflow), 32'(e.ov));
`endif
            end
        end
    end

    // Issues one operation, checks latency, optional backpressure hold, and return to IDLE
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic subOp,
                                 input logic [WIDTH-1:0] expRes, input logic expCarry,
                                 input logic expOv, input int hold);
        int waitCnt;
        int cycles;
        waitCnt = 0;
        @(negedge clk);
        while (inReady !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("in_ready_wait", 32'(inReady), 32'd1);
        inA     = a;
        inB     = b;
        carryIn = cin;
`ifdef NIBBLE_ADD_SUB_EN
        sub     = subOp;
`endif
        inValid = 1'b1;
        expQueue.push_back('{res: expRes, carry: expCarry, ov: expOv});
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inA     = '1;
        inB     = '1;
        carryIn = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
        sub     = ~subOp;
`endif
        cycles = 0;
        while (outValid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'd4);
        checkOutput("in_ready_in_done", 32'(inReady), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", 32'(outValid), 32'd1);
            checkOutput("hold_in_ready", 32'(inReady), 32'd0);
            checkOutput("hold_result", 32'(result), 32'(expRes));
            checkOutput("hold_carry", 32'(carryOut), 32'(expCarry));
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_hs_out_valid", 32'(outValid), 32'd0);
        checkOutput("post_hs_in_ready", 32'(inReady), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = 1'b0;
        inA      = '0;
        inB      = '0;
        carryIn  = 1'b0;
        outReady = 1'b1;
`ifdef NIBBLE_ADD_SUB_EN
        sub      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(inReady), 32'd1);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_carry", 32'(carryOut), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 0);

        outReady = 1'b0;
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 10);

        // Abort: reset lands on the second RUN cycle, nothing may be emitted
        @(negedge clk);
        inA     = 16'hABCD;
        inB     = 16'h1234;
        carryIn = 1'b0;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_in_ready", 32'(inReady), 32'd1);
        checkOutput("abort_out_valid", 32'(outValid), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_carry", 32'(carryOut), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_no_output", 32'(outValid), 32'd0);

        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

`ifdef NIBBLE_ADD_SUB_EN
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        applyStimulus(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQueue.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
